// File: rtl/mb_conta.sv
// Bank-side account responder: balance/PIN store with query, withdraw, deposit and PIN change.
// Optional daily withdrawal cap enabled by defining MB_DAY_LIMIT_EN.
module mb_conta #(
    parameter int             W          = 5,
    parameter logic [W-1:0]   SALDO_INIT = 5'd20,
    parameter logic [W-1:0]   PIN_INIT   = 5'b00110,
    parameter int             MAX_TRIES  = 3,
    parameter logic [W-1:0]   DAY_LIMIT  = 5'd25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [W-1:0] req_pin,
    input  logic [W-1:0] req_val,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [2:0]   rsp_status,
    output logic [W-1:0] rsp_saldo,
    input  logic         admin_unlock,
    input  logic         day_rst,
    output logic         locked,
    output logic [W-1:0] saldo_out
);

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_BAD_PIN  = 3'd1;
    localparam logic [2:0] ST_NO_FUNDS = 3'd2;
    localparam logic [2:0] ST_LOCKED   = 3'd3;
    localparam logic [2:0] ST_OVERFLOW = 3'd4;
    localparam logic [2:0] ST_LIMIT    = 3'd5;

    typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, RESP = 2'd2} state_t;

    state_t       state_r;
    logic [1:0]   op_r;
    logic [W-1:0] pin_in_r, val_r, saldo_r, pin_r, rsp_saldo_r;
    logic [2:0]   fail_r, rsp_status_r;
    logic         locked_r, req_ready_r, rsp_valid_r;

    logic [2:0]   st_s, fail_nx_s, fail_inc_s;
    logic [W-1:0] saldo_nx_s, pin_nx_s, rsp_sd_s;
    logic         lock_nx_s;
    logic [W:0]   sum_s;

`ifdef MB_DAY_LIMIT_EN
    logic [W:0]   total_r, total_nx_s;
    logic [W+1:0] day_sum_s;
`else
    logic         unused_s;
    assign unused_s = ^{day_rst, DAY_LIMIT};
`endif

    assign sum_s      = {1'b0, saldo_r} + {1'b0, val_r};
    assign fail_inc_s = fail_r + 3'd1;

    // Evaluate the captured request against the stored account state.
    always_comb begin
        st_s       = ST_OK;
        saldo_nx_s = saldo_r;
        pin_nx_s   = pin_r;
        fail_nx_s  = fail_r;
        lock_nx_s  = locked_r;
`ifdef MB_DAY_LIMIT_EN
        total_nx_s = total_r;
        day_sum_s  = {1'b0, total_r} + {2'b00, val_r};
`endif
        if (locked_r) begin
            st_s = ST_LOCKED;
        end else if (pin_in_r != pin_r) begin
            st_s      = ST_BAD_PIN;
            fail_nx_s = fail_inc_s;
            if (fail_inc_s >= 3'(MAX_TRIES)) begin
                lock_nx_s = 1'b1;
            end else begin
                lock_nx_s = 1'b0;
            end
        end else begin
            fail_nx_s = 3'd0;
            case (op_r)
                2'b00: st_s = ST_OK;
                2'b01: begin
`ifdef MB_DAY_LIMIT_EN
                    if (day_sum_s > {2'b00, DAY_LIMIT}) begin
                        st_s = ST_LIMIT;
                    end else if (val_r > saldo_r) begin
                        st_s = ST_NO_FUNDS;
                    end else begin
                        saldo_nx_s = saldo_r - val_r;
                        total_nx_s = day_sum_s[W:0];
                    end
`else
                    if (val_r > saldo_r) begin
                        st_s = ST_NO_FUNDS;
                    end else begin
                        saldo_nx_s = saldo_r - val_r;
                    end
`endif
                end
                2'b10: begin
                    if (sum_s[W]) begin
                        st_s = ST_OVERFLOW;
                    end else begin
                        saldo_nx_s = sum_s[W-1:0];
                    end
                end
                2'b11: pin_nx_s = val_r;
                default: st_s = ST_OK;
            endcase
        end
        // Never leak the balance on a refused authentication.
        if (st_s == ST_BAD_PIN || st_s == ST_LOCKED) begin
            rsp_sd_s = {W{1'b0}};
        end else begin
            rsp_sd_s = saldo_nx_s;
        end
    end

    // Request/response FSM and account registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            op_r         <= 2'b00;
            pin_in_r     <= {W{1'b0}};
            val_r        <= {W{1'b0}};
            saldo_r      <= SALDO_INIT;
            pin_r        <= PIN_INIT;
            fail_r       <= 3'd0;
            locked_r     <= 1'b0;
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_status_r <= 3'd0;
            rsp_saldo_r  <= {W{1'b0}};
`ifdef MB_DAY_LIMIT_EN
            total_r      <= {(W+1){1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready_r) begin
                        op_r        <= req_op;
                        pin_in_r    <= req_pin;
                        val_r       <= req_val;
                        req_ready_r <= 1'b0;
                        state_r     <= CHECK;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                CHECK: begin
                    saldo_r      <= saldo_nx_s;
                    pin_r        <= pin_nx_s;
                    fail_r       <= fail_nx_s;
                    locked_r     <= lock_nx_s;
                    rsp_status_r <= st_s;
                    rsp_saldo_r  <= rsp_sd_s;
`ifdef MB_DAY_LIMIT_EN
                    total_r      <= total_nx_s;
`endif
                    state_r      <= RESP;
                end
                RESP: begin
                    // First RESP cycle raises valid; the response is then held until accepted.
                    if (!rsp_valid_r) begin
                        rsp_valid_r <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                end
            endcase
            if (admin_unlock) begin
                locked_r <= 1'b0;
                fail_r   <= 3'd0;
            end
`ifdef MB_DAY_LIMIT_EN
            if (day_rst) begin
                total_r <= {(W+1){1'b0}};
            end
`endif
        end
    end

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_status = rsp_status_r;
    assign rsp_saldo  = rsp_saldo_r;
    assign locked     = locked_r;
    assign saldo_out  = saldo_r;

endmodule

// File: tb/tb_mb_conta.sv
// Directed self-checking bench for mb_conta; limit cases compile only with MB_DAY_LIMIT_EN.
module tb_mb_conta;

    logic       clk, rst_n, req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0] req_op;
    logic [4:0] req_pin, req_val, rsp_saldo, saldo_out;
    logic [2:0] rsp_status;
    logic       admin_unlock, day_rst, locked;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] st_o;
    logic [4:0] sd_o;
    int         lat_o;

    mb_conta dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_pin(req_pin), .req_val(req_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_saldo(rsp_saldo),
        .admin_unlock(admin_unlock), .day_rst(day_rst),
        .locked(locked), .saldo_out(saldo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request; optionally pulse admin_unlock during CHECK; optionally complete the handshake.
    task automatic send(input logic [1:0] op, input logic [4:0] pin, input logic [4:0] val,
                        input logic unl, input logic do_hs,
                        output logic [2:0] st, output logic [4:0] sd, output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_op = op; req_pin = pin; req_val = val;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        admin_unlock = unl;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            admin_unlock = 1'b0;
        end
        if (!rsp_valid) chk("rsp_valid_timeout", 32'd0, 32'd1);
        st = rsp_status;
        sd = rsp_saldo;
        if (do_hs) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic txn(input string tag, input logic [1:0] op, input logic [4:0] pin,
                       input logic [4:0] val, input logic [2:0] exp_st, input logic [4:0] exp_sd);
        send(op, pin, val, 1'b0, 1'b1, st_o, sd_o, lat_o);
        chk({tag, "_status"}, 32'(st_o), 32'(exp_st));
        chk({tag, "_saldo"}, 32'(sd_o), 32'(exp_sd));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_pin = 5'd0; req_val = 5'd0;
        rsp_ready = 1'b0; admin_unlock = 1'b0; day_rst = 1'b0;
        do_reset();
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_rsp_saldo", 32'(rsp_saldo), 32'd0);
        chk("rst_saldo_out", 32'(saldo_out), 32'd20);

        send(2'b00, 5'b00110, 5'd0, 1'b0, 1'b1, st_o, sd_o, lat_o);
        chk("query_latency", 32'(lat_o), 32'd2);
        chk("query_status", 32'(st_o), 32'd0);
        chk("query_saldo", 32'(sd_o), 32'd20);
        chk("query_saldo_out", 32'(saldo_out), 32'd20);
        chk("after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("after_hs_req_ready", 32'(req_ready), 32'd1);

        txn("wd7", 2'b01, 5'b00110, 5'd7, 3'd0, 5'd13);
        txn("wd14", 2'b01, 5'b00110, 5'd14, 3'd2, 5'd13);
        txn("wd0", 2'b01, 5'b00110, 5'd0, 3'd0, 5'd13);
        chk("wd_saldo_out", 32'(saldo_out), 32'd13);
        txn("chpin", 2'b11, 5'b00110, 5'd9, 3'd0, 5'd13);
        txn("oldpin", 2'b00, 5'b00110, 5'd0, 3'd1, 5'd0);
        txn("newpin", 2'b00, 5'd9, 5'd0, 3'd0, 5'd13);

        do_reset();
        txn("dep15", 2'b10, 5'b00110, 5'd15, 3'd4, 5'd20);
        txn("dep11", 2'b10, 5'b00110, 5'd11, 3'd0, 5'd31);

        txn("bad1", 2'b00, 5'd0, 5'd0, 3'd1, 5'd0);
        txn("bad2", 2'b00, 5'd0, 5'd0, 3'd1, 5'd0);
        chk("bad2_locked", 32'(locked), 32'd0);
        txn("bad3", 2'b01, 5'd0, 5'd5, 3'd1, 5'd0);
        chk("bad3_locked", 32'(locked), 32'd1);
        txn("lock_goodpin", 2'b01, 5'b00110, 5'd5, 3'd3, 5'd0);
        chk("lock_saldo_out", 32'(saldo_out), 32'd31);
        admin_unlock = 1'b1;
        @(negedge clk);
        admin_unlock = 1'b0;
        chk("unlock_locked", 32'(locked), 32'd0);
        txn("unlock_query", 2'b00, 5'b00110, 5'd0, 3'd0, 5'd31);

        // Unlock pulse landing on the CHECK cycle: the LOCKED answer stands, lock clears afterwards.
        do_reset();
        txn("b1", 2'b00, 5'd1, 5'd0, 3'd1, 5'd0);
        txn("b2", 2'b00, 5'd1, 5'd0, 3'd1, 5'd0);
        txn("b3", 2'b00, 5'd1, 5'd0, 3'd1, 5'd0);
        send(2'b00, 5'b00110, 5'd0, 1'b1, 1'b1, st_o, sd_o, lat_o);
        chk("unl_check_status", 32'(st_o), 32'd3);
        chk("unl_check_locked", 32'(locked), 32'd0);
        txn("unl_check_query", 2'b00, 5'b00110, 5'd0, 3'd0, 5'd20);

        send(2'b01, 5'b00110, 5'd3, 1'b0, 1'b0, st_o, sd_o, lat_o);
        chk("hold_status0", 32'(st_o), 32'd0);
        chk("hold_saldo0", 32'(sd_o), 32'd17);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_status", 32'(rsp_status), 32'd0);
            chk("hold_rsp_saldo", 32'(rsp_saldo), 32'd17);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_saldo", 32'(rsp_saldo), 32'd0);
        chk("midrst_saldo_out", 32'(saldo_out), 32'd20);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef MB_DAY_LIMIT_EN
        txn("lim_wd20", 2'b01, 5'b00110, 5'd20, 3'd0, 5'd0);
        txn("lim_dep10", 2'b10, 5'b00110, 5'd10, 3'd0, 5'd10);
        txn("lim_wd6", 2'b01, 5'b00110, 5'd6, 3'd5, 5'd10);
        day_rst = 1'b1;
        @(negedge clk);
        day_rst = 1'b0;
        txn("lim_after_rst", 2'b01, 5'b00110, 5'd6, 3'd0, 5'd4);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
